decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV32I decode stage, directly downstream of fetch's instruction queue.
//  - Pops {pc, inst} entries from the first-word-fall-through queue.
//  - Decodes each instruction into register indices, sign-extended immediate and control flags.
//  - Holds the result in a one-entry output register for the dispatch stage (valid/ready).
//  - Flush discards the in-flight entry; fetch redirects in parallel.
// PARAMETERS
//  RESET_IMM  32'h0  value driven on dec_imm while reset or invalid
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   reset, synchronous, active-high
//  flush        in   1   kill in-flight decode entry (redirect)
//  iq_empty     in   1   instruction queue empty
//  iq_pc        in   32  pc of queue head (valid when !iq_empty)
//  iq_inst      in   32  instruction word of queue head (valid when !iq_empty)
//  iq_dequeue   out  1   pop queue head at this posedge
//  dec_valid    out  1   output register holds a decoded instruction
//  dec_ready    in   1   dispatch accepts entry this cycle
//  dec_pc       out  32  pc of decoded instruction
//  dec_inst     out  32  raw instruction word
//  dec_rd       out  5   destination register index
//  dec_rs1      out  5   source 1 index
//  dec_rs2      out  5   source 2 index
//  dec_funct3   out  3   inst[14:12]
//  dec_funct7b5 out  1   inst[30]
//  dec_imm      out  32  sign-extended immediate per format
//  dec_flags    out  8   {illegal,is_jalr,is_jal,is_branch,is_store,is_load,uses_rs2,uses_rs1}
//  dec_writes_rd out 1   instruction writes a nonzero rd
// BEHAVIOUR
//  - Reset: dec_valid=0; all dec_* data=0 except dec_imm=RESET_IMM; iq_dequeue=0.
//  - Advance condition: adv = !dec_valid || dec_ready.
//  - iq_dequeue = !iq_empty && adv && !flush && !rst (combinational).
//  - Dequeue edge: output register loads the decode of iq_pc/iq_inst; dec_valid<=1.
//  - Latency: 1 cycle from the dequeue edge to dec_valid. Throughput: 1 instruction per cycle
//    while dec_ready=1.
//  - adv=1 with no dequeue: dec_valid<=0.
//  - Stall (dec_valid && !dec_ready): every dec_* output held stable; no dequeue.
//  - flush: dec_valid<=0 next edge regardless of dec_ready; no dequeue that cycle.
//    Flush has priority over load. Data fields may keep stale values.
//  - Opcode classes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011,
//    LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
//  - Immediates, sign-extended from inst[31]:
//    - I-type: inst[31:20]
//    - S-type: {inst[31:25],inst[11:7]}
//    - B-type: {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}
//    - U-type: {inst[31:12],12'b0}
//    - J-type: {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}
//    - OP: dec_imm=0
//  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
//  - uses_rs2: BRANCH, STORE, OP.
//  - dec_writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd!=0; else 0.
//  - illegal=1 for any of:
//    - unknown opcode or inst[1:0]!=2'b11
//    - BRANCH funct3 010/011
//    - LOAD funct3 011/110/111
//    - STORE funct3>=011
//    - JALR funct3!=000
//    - OP funct7 not 0000000/0100000, or funct7=0100000 with funct3 not 000/101
//    - OP-IMM shift (funct3 001) with funct7!=0000000
//    - OP-IMM shift (funct3 101) with funct7 not 0000000/0100000
//  - Illegal entries still flow to dispatch with writes_rd=0, uses_rs1=0, uses_rs2=0.
//  - Unused index fields are still driven from inst bits (rd=inst[11:7], rs1=inst[19:15],
//    rs2=inst[24:20]).
//  - Reset mid-stream: entry dropped, dec_valid=0 next edge, no dequeue during rst.
// TESTING
//  - Reset, then queue holds ADDI x1,x0,5 (0x00500093) at pc 0x1eceb000 -> 1 cycle later
//    dec_valid=1, rd=1, rs1=0, imm=5, writes_rd=1, uses_rs1=1.
//  - Back-to-back stream, dec_ready=1 -> iq_dequeue high every cycle, one dec_valid per cycle,
//    in order.
//  - dec_ready=0 for 3 cycles with BEQ x1,x2,-8 (0xfe208ce3) held -> outputs stable,
//    imm=0xfffffff8, iq_dequeue=0.
//  - flush while dec_valid=1 and dec_ready=0 -> next cycle dec_valid=0, no pop in the flush cycle.
//  - Word 0x00000000 and SUB-style funct7 on AND (0x4020f0b3) -> illegal=1, writes_rd=0.
//  - Immediate formats: SW (0xfe112e23) imm=0xfffffffc; LUI 0xabcde0b7 imm=0xabcde000;
//    JAL (0x0080006f) imm=8, rd=0 -> writes_rd=0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage sitting between fetch's instruction queue and dispatch.
//
// Pops {pc, inst} entries from a first-word-fall-through queue, decodes each into register
// indices, a sign-extended immediate and control flags, and holds the result in a one-entry
// output register handed to dispatch with a valid/ready handshake.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   flush             kill the entry in the output register; no pop in the same cycle
//   iq_empty          instruction queue has no head entry
//   iq_pc, iq_inst    queue head, valid when !iq_empty
//   iq_dequeue        pop the queue head at this posedge (combinational)
//   dec_valid         output register holds a decoded instruction
//   dec_ready         dispatch accepts the held entry this cycle
//   dec_pc, dec_inst  pc and raw word of the held instruction
//   dec_rd/rs1/rs2    register indices, always taken straight from the instruction bits
//   dec_funct3        inst[14:12]
//   dec_funct7b5      inst[30]
//   dec_imm           sign-extended immediate; RESET_IMM whenever dec_valid is low
//   dec_flags         {illegal, is_jalr, is_jal, is_branch, is_store, is_load, uses_rs2, uses_rs1}
//   dec_writes_rd     instruction writes a nonzero rd

module decode_stage #(
    parameter logic [31:0] RESET_IMM = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        iq_empty,
    input  logic [31:0] iq_pc,
    input  logic [31:0] iq_inst,
    output logic        iq_dequeue,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_inst,
    output logic [4:0]  dec_rd,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [2:0]  dec_funct3,
    output logic        dec_funct7b5,
    output logic [31:0] dec_imm,
    output logic [7:0]  dec_flags,
    output logic        dec_writes_rd
);

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    // ---------------------------------------------------------------------------------------
    // Combinational decode of the queue head
    // ---------------------------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_idx;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [31:0] imm_dec;
    logic        is_jalr, is_jal, is_branch, is_store, is_load;
    logic        uses_rs1, uses_rs2, illegal, wr_class;
    logic        writes_rd_dec;
    logic [7:0]  flags_dec;

    always_comb begin
        opcode = iq_inst[6:0];
        funct3 = iq_inst[14:12];
        funct7 = iq_inst[31:25];
        rd_idx = iq_inst[11:7];

        imm_i = {{20{iq_inst[31]}}, iq_inst[31:20]};
        imm_s = {{20{iq_inst[31]}}, iq_inst[31:25], iq_inst[11:7]};
        imm_b = {{19{iq_inst[31]}}, iq_inst[31], iq_inst[7], iq_inst[30:25], iq_inst[11:8], 1'b0};
        imm_u = {iq_inst[31:12], 12'b0};
        imm_j = {{11{iq_inst[31]}}, iq_inst[31], iq_inst[19:12], iq_inst[20], iq_inst[30:21],
                 1'b0};

        imm_dec   = '0;
        is_jalr   = 1'b0;
        is_jal    = 1'b0;
        is_branch = 1'b0;
        is_store  = 1'b0;
        is_load   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        illegal   = 1'b0;
        wr_class  = 1'b0;

        // The full 7-bit opcode compare also rejects inst[1:0] != 2'b11.
        case (opcode)
            OpcLui: begin
                imm_dec  = imm_u;
                wr_class = 1'b1;
            end
            OpcAuipc: begin
                imm_dec  = imm_u;
                wr_class = 1'b1;
            end
            OpcJal: begin
                imm_dec  = imm_j;
                is_jal   = 1'b1;
                wr_class = 1'b1;
            end
            OpcJalr: begin
                imm_dec  = imm_i;
                is_jalr  = 1'b1;
                uses_rs1 = 1'b1;
                wr_class = 1'b1;
                illegal  = (funct3 != 3'b000);
            end
            OpcBranch: begin
                imm_dec   = imm_b;
                is_branch = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpcLoad: begin
                imm_dec  = imm_i;
                is_load  = 1'b1;
                uses_rs1 = 1'b1;
                wr_class = 1'b1;
                illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OpcStore: begin
                imm_dec  = imm_s;
                is_store = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                illegal  = (funct3 >= 3'b011);
            end
            OpcOpImm: begin
                imm_dec  = imm_i;
                uses_rs1 = 1'b1;
                wr_class = 1'b1;
                // Shift-immediates reuse the upper immediate bits as funct7.
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != F7Zero);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != F7Zero) && (funct7 != F7Alt);
                end
            end
            OpcOp: begin
                imm_dec  = '0;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                wr_class = 1'b1;
                if ((funct7 != F7Zero) && (funct7 != F7Alt)) begin
                    illegal = 1'b1;
                end else if ((funct7 == F7Alt) && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        // Illegal entries still go downstream but must not touch the register file.
        if (illegal) begin
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end
        writes_rd_dec = wr_class && !illegal && (rd_idx != 5'd0);

        flags_dec = {illegal, is_jalr, is_jal, is_branch, is_store, is_load, uses_rs2, uses_rs1};
    end

    // ---------------------------------------------------------------------------------------
    // Handshake and output register
    // ---------------------------------------------------------------------------------------
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        funct7b5_q, funct7b5_d;
    logic [31:0] imm_q, imm_d;
    logic [7:0]  flags_q, flags_d;
    logic        writes_rd_q, writes_rd_d;

    logic adv;

    always_comb begin
        adv        = !valid_q || dec_ready;
        iq_dequeue = !iq_empty && adv && !flush && !rst;
    end

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        funct3_d    = funct3_q;
        funct7b5_d  = funct7b5_q;
        imm_d       = imm_q;
        flags_d     = flags_q;
        writes_rd_d = writes_rd_q;

        // Flush wins over a load; data fields are left stale since valid drops.
        if (flush) begin
            valid_d = 1'b0;
        end else if (iq_dequeue) begin
            valid_d     = 1'b1;
            pc_d        = iq_pc;
            inst_d      = iq_inst;
            rd_d        = iq_inst[11:7];
            rs1_d       = iq_inst[19:15];
            rs2_d       = iq_inst[24:20];
            funct3_d    = iq_inst[14:12];
            funct7b5_d  = iq_inst[30];
            imm_d       = imm_dec;
            flags_d     = flags_dec;
            writes_rd_d = writes_rd_dec;
        end else if (adv) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            inst_q      <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            funct3_q    <= '0;
            funct7b5_q  <= 1'b0;
            imm_q       <= RESET_IMM;
            flags_q     <= '0;
            writes_rd_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            funct3_q    <= funct3_d;
            funct7b5_q  <= funct7b5_d;
            imm_q       <= imm_d;
            flags_q     <= flags_d;
            writes_rd_q <= writes_rd_d;
        end
    end

    always_comb begin
        dec_valid     = valid_q;
        dec_pc        = pc_q;
        dec_inst      = inst_q;
        dec_rd        = rd_q;
        dec_rs1       = rs1_q;
        dec_rs2       = rs2_q;
        dec_funct3    = funct3_q;
        dec_funct7b5  = funct7b5_q;
        // Idle register presents the reset immediate rather than a stale one.
        dec_imm       = valid_q ? imm_q : RESET_IMM;
        dec_flags     = flags_q;
        dec_writes_rd = writes_rd_q;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: a small instruction-queue model feeds a table of RV32I words;
// each dequeued entry's expected decode is pushed to a scoreboard and checked while the DUT
// holds it, every cycle, so stalls must keep the outputs stable.

module tb_decode_stage;

    localparam logic [31:0] ResetImm = 32'h5a5a_0f0f;
    localparam int N = 14;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        iq_empty;
    logic [31:0] iq_pc;
    logic [31:0] iq_inst;
    logic        iq_dequeue;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [2:0]  dec_funct3;
    logic        dec_funct7b5;
    logic [31:0] dec_imm;
    logic [7:0]  dec_flags;
    logic        dec_writes_rd;

    decode_stage #(
        .RESET_IMM(ResetImm)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .iq_empty     (iq_empty),
        .iq_pc        (iq_pc),
        .iq_inst      (iq_inst),
        .iq_dequeue   (iq_dequeue),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_pc       (dec_pc),
        .dec_inst     (dec_inst),
        .dec_rd       (dec_rd),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_funct3   (dec_funct3),
        .dec_funct7b5 (dec_funct7b5),
        .dec_imm      (dec_imm),
        .dec_flags    (dec_flags),
        .dec_writes_rd(dec_writes_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [7:0]  flags;
        logic        wr;
    } entry_t;

    entry_t tbl [N];
    entry_t sb[$];

    int checks = 0;
    int errors = 0;
    int idx = 0;
    logic exp_valid = 1'b0;
    logic after_reset = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the negedge, check, then model the posedge.
    task automatic cyc(input logic r, input logic f, input logic rdy);
        logic exp_deq;
        entry_t e;
        rst       = r;
        flush     = f;
        dec_ready = rdy;
        iq_empty  = (idx >= N);
        iq_pc     = (idx < N) ? tbl[idx].pc : 32'h0;
        iq_inst   = (idx < N) ? tbl[idx].inst : 32'h0;
        #1;
        exp_deq = (idx < N) && (!exp_valid || rdy) && !f && !r;
        check_val("iq_dequeue", {31'b0, iq_dequeue}, {31'b0, exp_deq});
        check_val("dec_valid", {31'b0, dec_valid}, {31'b0, exp_valid});
        if (exp_valid && sb.size() > 0) begin
            e = sb[0];
            check_val("pc", dec_pc, e.pc);
            check_val("inst", dec_inst, e.inst);
            check_val("rd", {27'b0, dec_rd}, {27'b0, e.inst[11:7]});
            check_val("rs1", {27'b0, dec_rs1}, {27'b0, e.inst[19:15]});
            check_val("rs2", {27'b0, dec_rs2}, {27'b0, e.inst[24:20]});
            check_val("funct3", {29'b0, dec_funct3}, {29'b0, e.inst[14:12]});
            check_val("funct7b5", {31'b0, dec_funct7b5}, {31'b0, e.inst[30]});
            check_val("imm", dec_imm, e.imm);
            check_val("flags", {24'b0, dec_flags}, {24'b0, e.flags});
            check_val("writes_rd", {31'b0, dec_writes_rd}, {31'b0, e.wr});
        end else if (!exp_valid) begin
            check_val("imm_idle", dec_imm, ResetImm);
        end
        if (after_reset) begin
            check_val("rst_pc", dec_pc, 32'h0);
            check_val("rst_rd", {27'b0, dec_rd}, 32'h0);
            check_val("rst_flags", {24'b0, dec_flags}, 32'h0);
            check_val("rst_wr", {31'b0, dec_writes_rd}, 32'h0);
        end
        @(posedge clk);
        after_reset = r;
        if (r) begin
            sb.delete();
            exp_valid = 1'b0;
        end else if (f) begin
            sb.delete();
            exp_valid = 1'b0;
        end else begin
            if (exp_valid && rdy && sb.size() > 0) void'(sb.pop_front());
            if (exp_deq) begin
                sb.push_back(tbl[idx]);
                idx++;
                exp_valid = 1'b1;
            end else if (!exp_valid || rdy) begin
                exp_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_ent(input int i, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] imm, input logic [7:0] flags, input logic wr);
        tbl[i].pc    = pc;
        tbl[i].inst  = inst;
        tbl[i].imm   = imm;
        tbl[i].flags = flags;
        tbl[i].wr    = wr;
    endtask

    initial begin
        int budget;
        // flags = {illegal, jalr, jal, branch, store, load, uses_rs2, uses_rs1}
        set_ent(0,  32'h1eceb000, 32'h00500093, 32'h00000005, 8'h01, 1'b1); // addi x1,x0,5
        set_ent(1,  32'h1eceb004, 32'hfe208ce3, 32'hfffffff8, 8'h13, 1'b0); // beq x1,x2,-8
        set_ent(2,  32'h1eceb008, 32'hfe112e23, 32'hfffffffc, 8'h0b, 1'b0); // sw x1,-4(x2)
        set_ent(3,  32'h1eceb00c, 32'habcde0b7, 32'habcde000, 8'h00, 1'b1); // lui x1
        set_ent(4,  32'h1eceb010, 32'h0080006f, 32'h00000008, 8'h20, 1'b0); // jal x0,8
        set_ent(5,  32'h1eceb014, 32'h00000000, 32'h00000000, 8'h80, 1'b0); // all-zero word
        set_ent(6,  32'h1eceb018, 32'h4020f0b3, 32'h00000000, 8'h80, 1'b0); // and w/ funct7 alt
        set_ent(7,  32'h1eceb01c, 32'h00c280e7, 32'h0000000c, 8'h41, 1'b1); // jalr x1,12(x5)
        set_ent(8,  32'h1eceb020, 32'hffc12283, 32'hfffffffc, 8'h05, 1'b1); // lw x5,-4(x2)
        set_ent(9,  32'h1eceb024, 32'h12345197, 32'h12345000, 8'h00, 1'b1); // auipc x3
        set_ent(10, 32'h1eceb028, 32'h4030d093, 32'h00000403, 8'h01, 1'b1); // srai x1,x1,3
        set_ent(11, 32'h1eceb02c, 32'h40309093, 32'h00000403, 8'h80, 1'b0); // slli w/ funct7 alt
        set_ent(12, 32'h1eceb030, 32'h402080b3, 32'h00000000, 8'h03, 1'b1); // sub x1,x1,x2
        set_ent(13, 32'h1eceb034, 32'h00208033, 32'h00000000, 8'h03, 1'b0); // add x0,x1,x2

        rst = 1'b1; flush = 1'b0; dec_ready = 1'b1;
        iq_empty = 1'b1; iq_pc = '0; iq_inst = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        after_reset = 1'b1;

        cyc(1'b1, 1'b0, 1'b1);                 // reset with queue non-empty: no pop
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);                 // pop addi
        cyc(1'b0, 1'b0, 1'b1);                 // addi visible, pop beq
        repeat (3) cyc(1'b0, 1'b0, 1'b0);      // beq stalled
        repeat (4) cyc(1'b0, 1'b0, 1'b1);      // stream
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);                 // flush while stalled
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);                 // flush with ready high
        repeat (2) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);                 // mid-stream reset

        budget = 40;
        while ((idx < N || exp_valid) && budget > 0) begin
            cyc(1'b0, 1'b0, 1'b1);
            budget--;
        end
        check_val("drain", {31'b0, (idx >= N && !exp_valid)}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
